arb_mux_n_1: RTL and testbench
==============================

Name: arb_mux_n_1

Overview:
Parametrised N:1 multiplexer with per-channel valid/ready handshakes, a registered output and a built-in arbiter. It is the sequential successor to the combinational 4:1 mux: width, channel count and arbitration mode are generic, and the select is generated internally rather than driven by a port. It sits between multiple producer streams and a single consumer stream.

Parameters:
- N, 4, number of input channels (>=1)
- W, 8, data width per channel
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- SEL_W, (N>1 ? $clog2(N) : 1), select/index width (derived; not to be overridden)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  N  per-channel request
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_ready  out  N  one-hot (or zero) accept strobe
- out_valid  out  1  output register holds a beat
- out_data  out  W  registered data
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts the beat

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, out_sel=0, rr pointer=N-1 (so channel 0 has first priority). in_ready=0 while rst=1.
- load = !out_valid | out_ready (the output register is empty or draining this cycle).
- Arbitration is combinational each cycle over in_valid:
  - MODE 0: search starts at (ptr+1) mod N and wraps to ptr. The first valid channel wins.
  - MODE 1: the lowest-index valid channel wins. ptr is unused.
- in_ready[i] = load & grant[i]. At most one bit is set. A transfer on channel i is in_valid[i] & in_ready[i].
- On a transfer: out_data <= in_data[i], out_sel <= i, out_valid <= 1, and ptr <= i in MODE 0.
- If load=1 and there is no request: out_valid <= 0 (a beat consumed by out_ready is dropped). out_data and out_sel hold their last value.
- If out_valid=1 and out_ready=0: all in_ready=0, and out_valid, out_data, out_sel and ptr hold.
- Latency: one cycle from input transfer to out_valid. Full throughput of one beat per cycle while out_ready=1.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one. There is no bubble.
- With a single persistent requester, that requester is granted every cycle (the search wraps to ptr itself).
- N=1: the arbiter degenerates to in_ready[0]=load, and out_sel is always 0.
- Reset asserted mid-stream: the held beat is discarded and the pointer returns to N-1. No partial state survives.
- Producers must hold in_valid and in_data stable until transfer. The block does not check this.

Optional Feature:
- Macro ARB_MUX_PKT_LOCK_EN.
- When defined:
  - Adds input in_last [N], which marks the final beat of a packet.
  - A two-state FSM is added: IDLE and LOCKED.
  - IDLE → LOCKED on a transfer with in_last[i]=0. The locked channel index is stored.
  - While LOCKED, only the locked channel may be granted, even if others are valid. If the locked channel is idle, no grant is issued.
  - LOCKED → IDLE on a transfer from the locked channel with in_last=1.
  - Reset forces IDLE.
  - The rr pointer updates only on the last beat of a packet.
- When not defined: there is no in_last port and no FSM, and every beat is arbitrated independently.

Decomposition:
- Shared package arb_mux_pkg holds:
  - MODE_RR=0 and MODE_FIXED=1 constants
  - the SEL_W derivation function
  - a typedef for the lock FSM state (IDLE, LOCKED)
- Sub-module rr_arbiter (N, MODE parameters; inputs req, ptr, en; outputs grant one-hot and grant_idx) is the natural split. arb_mux_n_1 instantiates it and owns the output register and lock FSM.

Test Plan:
- Reset: rst=1 with in_valid=4'b1111 → out_valid=0, in_ready=0. After release, first grant goes to channel 0 (out_sel=0).
- Round-robin, N=4, W=8, MODE 0: all valid with data 8'hA0..8'hA3, out_ready=1 → out_sel sequence 0,1,2,3,0, with one beat per cycle.
- Backpressure: out_ready=0 while out_valid=1 with 8'hA1 → in_ready=0, and out_data stays 8'hA1 for 5 cycles. Raising out_ready delivers the next grant with no gap.
- Sparse and single requester: only in_valid[2]=1 → channel 2 is granted every cycle. Then valid=4'b1001 after ptr=2 → grant order 3,0.
- MODE 1: valid=4'b1110 persistent → channel 1 is always granted and channels 2 and 3 are starved (expected).
- ARB_MUX_PKT_LOCK_EN: channel 1 sends a 3-beat packet (last on beat 3) while channel 0 is valid → out_sel=1,1,1, then 0. Reset mid-packet → state returns to IDLE and channel 0 is granted first.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared constants, select-width helper and lock FSM state type for arb_mux_n_1.
package arb_mux_pkg;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;

   function automatic int sel_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin starting after ptr, or fixed lowest-index priority.
module rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int MODE  = MODE_RR,
   parameter int SEL_W = sel_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   input  logic             en,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] grant_idx
);

   int   w_start;
   int   w_cand;
   logic w_found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_cand    = 0;
      w_start   = (MODE == MODE_RR) ? ((int'(ptr) + 1) % N) : 0;
      // First requester found on the wrapped scan wins; the scan ends on ptr itself.
      for (int k = 0; k < N; k++) begin
         w_cand = (w_start + k) % N;
         if (!w_found && req[SEL_W'(w_cand)]) begin
            w_found                = 1'b1;
            grant[SEL_W'(w_cand)]  = en;
            grant_idx              = SEL_W'(w_cand);
         end
      end
   end

endmodule

// File: rtl/arb_mux_n_1.sv
// N:1 arbitrated stream mux with registered output. Define ARB_MUX_PKT_LOCK_EN to hold
// the grant on one channel until the beat flagged by in_last.
module arb_mux_n_1
   import arb_mux_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int MODE  = MODE_RR,
   parameter int SEL_W = sel_w(N)
) (
   input  logic             clk,
   input  logic             rst,
`ifdef ARB_MUX_PKT_LOCK_EN
   input  logic [N-1:0]     in_last,
`endif
   input  logic [N-1:0]     in_valid,
   input  logic [N*W-1:0]   in_data,
   output logic [N-1:0]     in_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_sel,
   input  logic             out_ready
);

   logic             r_out_valid;
   logic [W-1:0]     r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic [SEL_W-1:0] r_ptr;

   logic             w_load;
   logic             w_en;
   logic [N-1:0]     w_req;
   logic [N-1:0]     w_grant;
   logic [SEL_W-1:0] w_idx;
   logic             w_xfer;
   logic             w_ptr_upd;
   logic [W-1:0]     w_ch_data [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_split
      assign w_ch_data[gi] = in_data[gi*W +: W];
   end

   assign w_load = !r_out_valid || out_ready;
   assign w_en   = w_load && !rst;
   assign w_xfer = |w_grant;

`ifdef ARB_MUX_PKT_LOCK_EN
   lock_state_t      r_lock_state;
   lock_state_t      w_lock_state_next;
   logic [SEL_W-1:0] r_lock_idx;
   logic [SEL_W-1:0] w_lock_idx_next;

   // While a packet is open only the owning channel is visible to the arbiter.
   always_comb begin
      w_req = in_valid;
      if (r_lock_state == ST_LOCKED) begin
         w_req = in_valid & (N'(1) << r_lock_idx);
      end
   end

   assign w_ptr_upd = in_last[w_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_state <= ST_IDLE;
         r_lock_idx   <= '0;
      end else begin
         r_lock_state <= w_lock_state_next;
         r_lock_idx   <= w_lock_idx_next;
      end
   end

   always_comb begin
      w_lock_state_next = r_lock_state;
      w_lock_idx_next   = r_lock_idx;
      case (r_lock_state)
         ST_IDLE: begin
            if (w_xfer && !in_last[w_idx]) begin
               w_lock_state_next = ST_LOCKED;
               w_lock_idx_next   = w_idx;
            end
         end
         ST_LOCKED: begin
            if (w_xfer && in_last[w_idx]) begin
               w_lock_state_next = ST_IDLE;
            end
         end
         default: w_lock_state_next = ST_IDLE;
      endcase
   end
`else
   assign w_req     = in_valid;
   assign w_ptr_upd = 1'b1;
`endif

   rr_arbiter #(
      .N     (N),
      .MODE  (MODE),
      .SEL_W (SEL_W)
   ) u_arb (
      .req       (w_req),
      .ptr       (r_ptr),
      .en        (w_en),
      .grant     (w_grant),
      .grant_idx (w_idx)
   );

   // A new beat may overwrite one being drained in the same cycle, so no bubble appears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_ptr       <= SEL_W'(N - 1);
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_ch_data[w_idx];
         r_out_sel   <= w_idx;
         if (MODE == MODE_RR && w_ptr_upd) begin
            r_ptr <= w_idx;
         end
      end else if (w_load) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_grant;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_n_1.sv
// Directed plus random bench for arb_mux_n_1: round-robin and fixed-priority instances
// compared cycle by cycle against a queue-free behavioural model.
module tb_arb_mux_n_1;

   localparam int N     = 4;
   localparam int W     = 8;
   localparam int SEL_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     in_valid;
   logic [N*W-1:0]   in_data;
   logic [W-1:0]     ch [N];
   logic             out_ready;
   logic [N-1:0]     rdy0, rdy1;
   logic             ov0, ov1;
   logic [W-1:0]     od0, od1;
   logic [SEL_W-1:0] os0, os1;
`ifdef ARB_MUX_PKT_LOCK_EN
   logic [N-1:0]     in_last;
`endif

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) in_data[k*W +: W] = ch[k];
   end

   arb_mux_n_1 #(.N(N), .W(W), .MODE(0)) u_rr (
      .clk(clk), .rst(rst),
`ifdef ARB_MUX_PKT_LOCK_EN
      .in_last(in_last),
`endif
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
      .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(out_ready)
   );

   arb_mux_n_1 #(.N(N), .W(W), .MODE(1)) u_fx (
      .clk(clk), .rst(rst),
`ifdef ARB_MUX_PKT_LOCK_EN
      .in_last(in_last),
`endif
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
      .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(out_ready)
   );

   int checks   = 0;
   int failures = 0;

   // Model state per instance: 0 = round-robin, 1 = fixed priority.
   int       m_ptr   [2];
   bit       m_valid [2];
   int       m_data  [2];
   int       m_sel   [2];
   int       m_lock  [2];   // owning channel of an open packet, -1 when none

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit last_of(input int c);
`ifdef ARB_MUX_PKT_LOCK_EN
      return in_last[2'(c)];
`else
      return (c >= 0);
`endif
   endfunction

   // Winner under the stated rules, or -1 when nothing may move this cycle.
   function automatic int pick(input int inst);
      int start;
      int c;
      if (m_valid[inst] && !out_ready) return -1;
      start = (inst == 0) ? (m_ptr[inst] + 1) % N : 0;
      for (int k = 0; k < N; k++) begin
         c = (start + k) % N;
         if (in_valid[2'(c)] && (m_lock[inst] < 0 || m_lock[inst] == c)) return c;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ptr[i] = N - 1; m_valid[i] = 0; m_data[i] = 0; m_sel[i] = 0; m_lock[i] = -1;
      end
   endfunction

   task automatic cycle();
      int          g   [2];
      int          d   [2];
      bit          lst [2];
      logic [N-1:0] exp_rdy;
      #1;
      for (int i = 0; i < 2; i++) begin
         g[i]   = pick(i);
         d[i]   = (g[i] >= 0) ? int'(ch[2'(g[i])]) : 0;
         lst[i] = (g[i] >= 0) ? last_of(g[i]) : 1'b0;
         exp_rdy = '0;
         if (g[i] >= 0) exp_rdy[2'(g[i])] = 1'b1;
         chk(i == 0 ? "in_ready_rr" : "in_ready_fx", 32'(i == 0 ? rdy0 : rdy1), 32'(exp_rdy));
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (g[i] >= 0) begin
            m_valid[i] = 1; m_data[i] = d[i]; m_sel[i] = g[i];
`ifdef ARB_MUX_PKT_LOCK_EN
            if (m_lock[i] < 0 && !lst[i]) m_lock[i] = g[i];
            else if (m_lock[i] == g[i] && lst[i]) m_lock[i] = -1;
            if (i == 0 && lst[i]) m_ptr[i] = g[i];
`else
            if (i == 0 && lst[i]) m_ptr[i] = g[i];
`endif
         end else if (!m_valid[i] || out_ready) begin
            m_valid[i] = 0;
         end
      end
      #1;
      chk("out_valid_rr", 32'(ov0), 32'(m_valid[0]));
      chk("out_data_rr",  32'(od0), 32'(m_data[0]));
      chk("out_sel_rr",   32'(os0), 32'(m_sel[0]));
      chk("out_valid_fx", 32'(ov1), 32'(m_valid[1]));
      chk("out_data_fx",  32'(od1), 32'(m_data[1]));
      chk("out_sel_fx",   32'(os1), 32'(m_sel[1]));
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_in_ready", 32'(rdy0 | rdy1), 32'(0));
      chk("rst_out_valid", 32'(ov0 | ov1), 32'(0));
      chk("rst_out_sel", 32'(os0), 32'(0));
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < N; k++) ch[k] = 8'hA0 + 8'(k);
`ifdef ARB_MUX_PKT_LOCK_EN
      in_last = 4'b1111;
`endif
      @(negedge clk);
      @(negedge clk);
      do_reset();

      // Round-robin over four persistent requesters.
      for (int s = 0; s < 5; s++) begin
         cycle();
         chk("rr_seq", 32'(os0), 32'(s % 4));
         chk("fx_seq", 32'(os1), 32'(0));
      end

      // Hold a beat from channel 1 under backpressure.
      cycle();
      chk("bp_first", 32'(od0), 32'(8'hA1));
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         cycle();
         chk("bp_hold_data", 32'(od0), 32'(8'hA1));
         chk("bp_hold_rdy", 32'(rdy0), 32'(0));
      end
      out_ready = 1'b1;
      cycle();
      chk("bp_release", 32'(os0), 32'(2));

      // Single requester, then wrap from ptr=2.
      in_valid = 4'b0100;
      for (int s = 0; s < 3; s++) begin
         cycle();
         chk("single_req", 32'(os0), 32'(2));
      end
      in_valid = 4'b1001;
      cycle();
      chk("sparse_a", 32'(os0), 32'(3));
      cycle();
      chk("sparse_b", 32'(os0), 32'(0));

      // Fixed priority starves higher indices.
      in_valid = 4'b1110;
      for (int s = 0; s < 4; s++) begin
         cycle();
         chk("fixed_prio", 32'(os1), 32'(1));
      end

`ifdef ARB_MUX_PKT_LOCK_EN
      do_reset();
      in_valid = 4'b0010; in_last = 4'b1101;
      cycle();
      chk("pkt_b1", 32'(os0), 32'(1));
      in_valid = 4'b0011;
      cycle();
      chk("pkt_b2", 32'(os0), 32'(1));
      in_last = 4'b1111;
      cycle();
      chk("pkt_b3", 32'(os0), 32'(1));
      cycle();
      chk("pkt_after", 32'(os0), 32'(0));
      in_valid = 4'b0010; in_last = 4'b1101;
      cycle();
      do_reset();
      in_valid = 4'b0011; in_last = 4'b1111;
      cycle();
      chk("pkt_reset_first", 32'(os0), 32'(0));
      chk("pkt_reset_first_fx", 32'(os1), 32'(0));
`endif

      // Random traffic with occasional mid-stream reset.
      for (int s = 0; s < 400; s++) begin
         in_valid  = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < N; k++) ch[k] = 8'($urandom);
`ifdef ARB_MUX_PKT_LOCK_EN
         in_last = 4'($urandom_range(0, 15));
`endif
         if ($urandom_range(0, 49) == 0) do_reset();
         else cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
